// File: rtl/prm_edge_mask_engine_if.sv
// rtl/prm_edge_mask_engine_if.sv - per-edge mask result stream (valid/ready)
interface prm_edge_mask_engine_if #(
  parameter int EDGE_W = 10
);
  logic              out_valid;
  logic              out_ready;
  logic [EDGE_W-1:0] out_edge_id;
  logic              out_mask;

  modport master (
    output out_valid,
    output out_edge_id,
    output out_mask,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_edge_id,
    input  out_mask,
    output out_ready
  );
endinterface

// File: rtl/prm_edge_mask_engine.sv
// rtl/prm_edge_mask_engine.sv - table-driven sum-of-products edge mask scanner
// Optional macro PRM_BLOCKED_COUNT_EN adds blocked_cnt (blocked edges in the current scan).
module prm_edge_mask_engine #(
  parameter int N_VARS     = 15,
  parameter int TERM_DEPTH = 1024,
  parameter int EDGE_W     = 10,
  parameter int ADDR_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [2*N_VARS+1:0]    cfg_wdata,
  input  logic                   start,
  input  logic [N_VARS-1:0]      occ,
  input  logic [ADDR_W:0]        n_terms,
  output logic                   busy,
  output logic                   done,
`ifdef PRM_BLOCKED_COUNT_EN
  output logic [EDGE_W:0]        blocked_cnt,
`endif
  prm_edge_mask_engine_if.master res
);

  localparam int TERM_W = 2*N_VARS + 2;

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, EMIT, FIN} state_t;

  state_t              state;
  logic [TERM_W-1:0]   term_mem [TERM_DEPTH];
  logic [TERM_W-1:0]   rd_term;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W:0]     ptr;
  logic [ADDR_W:0]     ptr_inc;
  logic [ADDR_W:0]     n_terms_q;
  logic [N_VARS-1:0]   occ_q;
  logic                acc;
  logic                acc_next;
  logic [N_VARS-1:0]   t_val;
  logic [N_VARS-1:0]   t_care;
  logic                t_en;
  logic                t_last;
  logic                term_match;
  logic                term_last;

  assign t_val   = rd_term[N_VARS-1:0];
  assign t_care  = rd_term[2*N_VARS-1:N_VARS];
  assign t_en    = rd_term[2*N_VARS];
  assign t_last  = rd_term[2*N_VARS+1];

  assign ptr_inc    = ptr + 1'b1;
  assign term_match = t_en && (((occ_q ^ t_val) & t_care) == '0);
  // The final entry of the scan closes its edge even without last set.
  assign term_last  = t_last || (ptr_inc == n_terms_q);
  assign acc_next   = acc | term_match;

  // While evaluating entry ptr, entry ptr+1 is already addressed so terms retire one per cycle.
  assign rd_addr = (state == EVAL) ? ptr_inc[ADDR_W-1:0] : ptr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst_n && cfg_we && (state == IDLE)) begin
      term_mem[cfg_addr] <= cfg_wdata;
    end
    rd_term <= term_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      res.out_valid   <= 1'b0;
      res.out_edge_id <= '0;
      res.out_mask    <= 1'b0;
      ptr             <= '0;
      n_terms_q       <= '0;
      occ_q           <= '0;
      acc             <= 1'b0;
`ifdef PRM_BLOCKED_COUNT_EN
      blocked_cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            occ_q           <= occ;
            n_terms_q       <= n_terms;
            ptr             <= '0;
            acc             <= 1'b0;
            res.out_edge_id <= '0;
            busy            <= 1'b1;
`ifdef PRM_BLOCKED_COUNT_EN
            blocked_cnt     <= '0;
`endif
            if (n_terms == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          state <= EVAL;
        end
        EVAL: begin
          ptr <= ptr_inc;
          if (term_last) begin
            state         <= EMIT;
            res.out_valid <= 1'b1;
            res.out_mask  <= acc_next;
          end else begin
            acc <= acc_next;
          end
        end
        EMIT: begin
          if (res.out_ready) begin
            res.out_valid   <= 1'b0;
            res.out_edge_id <= res.out_edge_id + 1'b1;
            acc             <= 1'b0;
`ifdef PRM_BLOCKED_COUNT_EN
            blocked_cnt     <= blocked_cnt + {{EDGE_W{1'b0}}, res.out_mask};
`endif
            if (ptr < n_terms_q) begin
              state <= FETCH;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
